// File: rtl/lc3_writeback_if.sv
// LC3 writeback stage bus: execute results in, register read ports and flags out.
interface lc3_writeback_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 8
);
    localparam int unsigned AW = $clog2(NREG);

    logic [DATA_W-1:0] aluout;
    logic              alucarry;
    logic [DATA_W-1:0] memout;
    logic [DATA_W-1:0] pcout;
    logic [1:0]        select_writeback;
    logic              enable_writeback;
    logic [AW-1:0]     dr;
    logic [AW-1:0]     sr1;
    logic [AW-1:0]     sr2;
    logic [DATA_W-1:0] VSR1;
    logic [DATA_W-1:0] VSR2;
    logic [2:0]        psr;
    logic              carry_flag;
    logic              wb_illegal;

    // Upstream pipeline / decode side.
    modport master (
        output aluout, alucarry, memout, pcout, select_writeback, enable_writeback,
        output dr, sr1, sr2,
        input  VSR1, VSR2, psr, carry_flag, wb_illegal
    );

    // Writeback stage side.
    modport slave (
        input  aluout, alucarry, memout, pcout, select_writeback, enable_writeback,
        input  dr, sr1, sr2,
        output VSR1, VSR2, psr, carry_flag, wb_illegal
    );
endinterface

// File: rtl/lc3_writeback.sv
// LC3 writeback stage: retires ALU/memory/PC result into the register file,
// updates NZP and carry, and serves the two decode read ports.
module lc3_writeback #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 8,
    parameter bit          BYPASS = 1'b1
) (
    input logic           clock,
    input logic           reset,
    lc3_writeback_if.slave wb
);
    localparam int unsigned AW = $clog2(NREG);

    localparam logic [1:0] SelAlu     = 2'd0;
    localparam logic [1:0] SelMem     = 2'd1;
    localparam logic [1:0] SelPc      = 2'd2;
    localparam logic [1:0] SelIllegal = 2'd3;

    localparam logic [2:0] PsrN = 3'b100;
    localparam logic [2:0] PsrZ = 3'b010;
    localparam logic [2:0] PsrP = 3'b001;

    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [2:0]        psr_q, psr_d;
    logic              carry_q, carry_d;
    logic              illegal_q, illegal_d;

    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              sel_illegal;

    // Result mux and write qualification.
    always_comb begin
        wr_data     = '0;
        sel_illegal = 1'b0;
        unique case (wb.select_writeback)
            SelAlu:     wr_data = wb.aluout;
            SelMem:     wr_data = wb.memout;
            SelPc:      wr_data = wb.pcout;
            SelIllegal: sel_illegal = 1'b1;
            default:    sel_illegal = 1'b1;
        endcase
        wr_en = wb.enable_writeback & ~sel_illegal;
    end

    // Next-state for register file, condition code, carry and illegal pulse.
    always_comb begin
        rf_d      = rf_q;
        psr_d     = psr_q;
        carry_d   = carry_q;
        illegal_d = wb.enable_writeback & sel_illegal;
        if (wr_en) begin
            rf_d[wb.dr] = wr_data;
            if (wr_data[DATA_W-1]) begin
                psr_d = PsrN;
            end else if (wr_data == '0) begin
                psr_d = PsrZ;
            end else begin
                psr_d = PsrP;
            end
            // Only ALU results carry a meaningful carry-out.
            if (wb.select_writeback == SelAlu) begin
                carry_d = wb.alucarry;
            end
        end
    end

    // State registers with synchronous active-low reset taking priority over writes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            psr_q     <= PsrZ;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            rf_q      <= rf_d;
            psr_q     <= psr_d;
            carry_q   <= carry_d;
            illegal_q <= illegal_d;
        end
    end

    // Read ports, optionally forwarding the value being retired this cycle.
    generate
        if (BYPASS) begin : g_bypass
            always_comb begin
                wb.VSR1 = rf_q[wb.sr1];
                wb.VSR2 = rf_q[wb.sr2];
                if (wr_en && (wb.sr1 == wb.dr)) begin
                    wb.VSR1 = wr_data;
                end
                if (wr_en && (wb.sr2 == wb.dr)) begin
                    wb.VSR2 = wr_data;
                end
            end
        end else begin : g_no_bypass
            always_comb begin
                wb.VSR1 = rf_q[wb.sr1];
                wb.VSR2 = rf_q[wb.sr2];
            end
        end
    endgenerate

    assign wb.psr        = psr_q;
    assign wb.carry_flag = carry_q;
    assign wb.wb_illegal = illegal_q;

    // Condition code must always hold exactly one of N, Z, P.
    a_psr_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot(psr_q));

    // The illegal pulse only follows an illegal strobe.
    a_illegal_cause: assert property (@(posedge clock) disable iff (!reset)
        illegal_q |-> $past(wb.enable_writeback && sel_illegal));

    logic unused_aw;
    assign unused_aw = ^AW;
endmodule

// File: tb/tb_lc3_writeback.sv
// Self-checking bench for lc3_writeback: directed scenarios plus a randomized
// run against a behavioural register-file model, on both BYPASS settings.
module tb_lc3_writeback;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    lc3_writeback_if #(.DATA_W(16), .NREG(8)) wb1_if ();
    lc3_writeback_if #(.DATA_W(16), .NREG(8)) wb0_if ();

    // Bypass-off instance mirrors the same stimulus.
    assign wb0_if.aluout           = wb1_if.aluout;
    assign wb0_if.alucarry         = wb1_if.alucarry;
    assign wb0_if.memout           = wb1_if.memout;
    assign wb0_if.pcout            = wb1_if.pcout;
    assign wb0_if.select_writeback = wb1_if.select_writeback;
    assign wb0_if.enable_writeback = wb1_if.enable_writeback;
    assign wb0_if.dr               = wb1_if.dr;
    assign wb0_if.sr1              = wb1_if.sr1;
    assign wb0_if.sr2              = wb1_if.sr2;

    lc3_writeback #(.DATA_W(16), .NREG(8), .BYPASS(1'b1)) u_byp (
        .clock (clock),
        .reset (reset),
        .wb    (wb1_if.slave)
    );

    lc3_writeback #(.DATA_W(16), .NREG(8), .BYPASS(1'b0)) u_nobyp (
        .clock (clock),
        .reset (reset),
        .wb    (wb0_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state.
    logic [15:0] m_rf [8];
    logic [2:0]  m_psr;
    logic        m_carry;
    logic        m_ill;

    function automatic logic [15:0] sel_value();
        case (wb1_if.select_writeback)
            2'd0:    return wb1_if.aluout;
            2'd1:    return wb1_if.memout;
            default: return wb1_if.pcout;
        endcase
    endfunction

    function automatic logic [2:0] nzp(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'd0) return 3'b010;
        return 3'b001;
    endfunction

    // Expected read-port value for a given source index and bypass setting.
    function automatic logic [15:0] exp_read(input logic [2:0] sr, input bit byp);
        if (byp && wb1_if.enable_writeback && wb1_if.select_writeback != 2'd3 &&
            sr == wb1_if.dr) return sel_value();
        return m_rf[sr];
    endfunction

    task automatic set_in(input logic en, input logic [1:0] sel, input logic [2:0] dr,
                          input logic [15:0] alu, input logic cy, input logic [15:0] mem,
                          input logic [15:0] pc);
        wb1_if.enable_writeback = en;
        wb1_if.select_writeback = sel;
        wb1_if.dr               = dr;
        wb1_if.aluout           = alu;
        wb1_if.alucarry         = cy;
        wb1_if.memout           = mem;
        wb1_if.pcout            = pc;
    endtask

    // Advance the model by the edge about to occur, then take the edge.
    task automatic tick();
        logic [15:0] v;
        if (!reset) begin
            for (int i = 0; i < 8; i++) m_rf[i] = 16'd0;
            m_psr   = 3'b010;
            m_carry = 1'b0;
            m_ill   = 1'b0;
        end else if (wb1_if.enable_writeback) begin
            if (wb1_if.select_writeback == 2'd3) begin
                m_ill = 1'b1;
            end else begin
                v = sel_value();
                m_rf[wb1_if.dr] = v;
                m_psr = nzp(v);
                if (wb1_if.select_writeback == 2'd0) m_carry = wb1_if.alucarry;
                m_ill = 1'b0;
            end
        end else begin
            m_ill = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_in(1'b0, 2'd0, 3'd0, 16'd0, 1'b0, 16'd0, 16'd0);
        wb1_if.sr1 = 3'd0;
        wb1_if.sr2 = 3'd0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            wb1_if.sr1 = 3'(i);
            wb1_if.sr2 = 3'(7 - i);
            #1;
            checks++; if (wb1_if.VSR1 !== 16'd0) begin errors++;
                $display("FAIL reset_vsr1 R%0d: got %h want 0000", i, wb1_if.VSR1); end
            checks++; if (wb0_if.VSR2 !== 16'd0) begin errors++;
                $display("FAIL reset_vsr2 R%0d: got %h want 0000", 7 - i, wb0_if.VSR2); end
        end
        checks++; if (wb1_if.psr !== 3'b010) begin errors++;
            $display("FAIL reset_psr: got %b want 010", wb1_if.psr); end
        checks++; if (wb1_if.carry_flag !== 1'b0) begin errors++;
            $display("FAIL reset_carry: got %b want 0", wb1_if.carry_flag); end
        checks++; if (wb1_if.wb_illegal !== 1'b0) begin errors++;
            $display("FAIL reset_illegal: got %b want 0", wb1_if.wb_illegal); end
    endtask

    task automatic test_write_nzp();
        set_in(1'b1, 2'd0, 3'd3, 16'h8001, 1'b1, 16'h5555, 16'h6666);
        tick();
        set_in(1'b0, 2'd0, 3'd3, 16'h0000, 1'b0, 16'h5555, 16'h6666);
        wb1_if.sr1 = 3'd3;
        #1;
        checks++; if (wb1_if.VSR1 !== 16'h8001) begin errors++;
            $display("FAIL t2_r3_alu: got %h want 8001", wb1_if.VSR1); end
        checks++; if (wb1_if.psr !== 3'b100) begin errors++;
            $display("FAIL t2_psr_n: got %b want 100", wb1_if.psr); end
        checks++; if (wb1_if.carry_flag !== 1'b1) begin errors++;
            $display("FAIL t2_carry_set: got %b want 1", wb1_if.carry_flag); end
        set_in(1'b1, 2'd1, 3'd3, 16'h0001, 1'b0, 16'h0000, 16'h6666);
        tick();
        wb1_if.enable_writeback = 1'b0;
        #1;
        checks++; if (wb1_if.VSR1 !== 16'h0000) begin errors++;
            $display("FAIL t2_r3_mem: got %h want 0000", wb1_if.VSR1); end
        checks++; if (wb1_if.psr !== 3'b010) begin errors++;
            $display("FAIL t2_psr_z: got %b want 010", wb1_if.psr); end
        checks++; if (wb1_if.carry_flag !== 1'b1) begin errors++;
            $display("FAIL t2_carry_hold: got %b want 1", wb1_if.carry_flag); end
    endtask

    task automatic test_bypass();
        set_in(1'b1, 2'd0, 3'd5, 16'h00aa, 1'b0, 16'd0, 16'd0);
        tick();
        set_in(1'b1, 2'd2, 3'd5, 16'h1111, 1'b1, 16'h2222, 16'h3005);
        wb1_if.sr1 = 3'd5;
        wb1_if.sr2 = 3'd5;
        #1;
        checks++; if (wb1_if.VSR1 !== 16'h3005) begin errors++;
            $display("FAIL t3_byp_vsr1: got %h want 3005", wb1_if.VSR1); end
        checks++; if (wb1_if.VSR2 !== 16'h3005) begin errors++;
            $display("FAIL t3_byp_vsr2: got %h want 3005", wb1_if.VSR2); end
        checks++; if (wb0_if.VSR1 !== 16'h00aa) begin errors++;
            $display("FAIL t3_nobyp_vsr1_pre: got %h want 00aa", wb0_if.VSR1); end
        checks++; if (wb0_if.VSR2 !== 16'h00aa) begin errors++;
            $display("FAIL t3_nobyp_vsr2_pre: got %h want 00aa", wb0_if.VSR2); end
        tick();
        wb1_if.enable_writeback = 1'b0;
        #1;
        checks++; if (wb0_if.VSR1 !== 16'h3005) begin errors++;
            $display("FAIL t3_nobyp_vsr1_post: got %h want 3005", wb0_if.VSR1); end
        checks++; if (wb0_if.VSR2 !== 16'h3005) begin errors++;
            $display("FAIL t3_nobyp_vsr2_post: got %h want 3005", wb0_if.VSR2); end
        checks++; if (wb1_if.carry_flag !== 1'b0) begin errors++;
            $display("FAIL t3_carry_hold: got %b want 0", wb1_if.carry_flag); end
    endtask

    task automatic test_illegal();
        set_in(1'b1, 2'd0, 3'd2, 16'h0007, 1'b1, 16'd0, 16'd0);
        tick();
        set_in(1'b1, 2'd3, 3'd2, 16'hffff, 1'b0, 16'h8000, 16'h8000);
        wb1_if.sr1 = 3'd2;
        #1;
        checks++; if (wb1_if.VSR1 !== 16'h0007) begin errors++;
            $display("FAIL t4_no_forward: got %h want 0007", wb1_if.VSR1); end
        tick();
        wb1_if.enable_writeback = 1'b0;
        #1;
        checks++; if (wb1_if.wb_illegal !== 1'b1) begin errors++;
            $display("FAIL t4_pulse: got %b want 1", wb1_if.wb_illegal); end
        checks++; if (wb1_if.VSR1 !== 16'h0007) begin errors++;
            $display("FAIL t4_r2_hold: got %h want 0007", wb1_if.VSR1); end
        checks++; if (wb1_if.psr !== 3'b001) begin errors++;
            $display("FAIL t4_psr_hold: got %b want 001", wb1_if.psr); end
        checks++; if (wb1_if.carry_flag !== 1'b1) begin errors++;
            $display("FAIL t4_carry_hold: got %b want 1", wb1_if.carry_flag); end
        tick();
        checks++; if (wb1_if.wb_illegal !== 1'b0) begin errors++;
            $display("FAIL t4_pulse_end: got %b want 0", wb1_if.wb_illegal); end
        // Back-to-back illegal strobes keep the pulse high each cycle.
        set_in(1'b1, 2'd3, 3'd1, 16'd0, 1'b0, 16'd0, 16'd0);
        tick();
        tick();
        checks++; if (wb1_if.wb_illegal !== 1'b1) begin errors++;
            $display("FAIL t4_b2b_pulse: got %b want 1", wb1_if.wb_illegal); end
        wb1_if.enable_writeback = 1'b0;
        tick();
        checks++; if (wb1_if.wb_illegal !== 1'b0) begin errors++;
            $display("FAIL t4_b2b_end: got %b want 0", wb1_if.wb_illegal); end
    endtask

    task automatic test_reset_collision();
        set_in(1'b1, 2'd0, 3'd1, 16'h0042, 1'b1, 16'd0, 16'd0);
        tick();
        reset = 1'b0;
        set_in(1'b1, 2'd0, 3'd1, 16'h1234, 1'b1, 16'd0, 16'd0);
        tick();
        reset = 1'b1;
        wb1_if.enable_writeback = 1'b0;
        wb1_if.sr1 = 3'd1;
        wb1_if.sr2 = 3'd1;
        #1;
        checks++; if (wb1_if.VSR1 !== 16'h0000) begin errors++;
            $display("FAIL t5_r1: got %h want 0000", wb1_if.VSR1); end
        checks++; if (wb0_if.VSR2 !== 16'h0000) begin errors++;
            $display("FAIL t5_r1_nobyp: got %h want 0000", wb0_if.VSR2); end
        checks++; if (wb1_if.psr !== 3'b010) begin errors++;
            $display("FAIL t5_psr: got %b want 010", wb1_if.psr); end
        checks++; if (wb1_if.carry_flag !== 1'b0) begin errors++;
            $display("FAIL t5_carry: got %b want 0", wb1_if.carry_flag); end
    endtask

    task automatic test_sweep();
        logic [2:0] want_psr;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 2'd0, 3'(i), 16'(16'h0010 * i), 1'b0, 16'd0, 16'd0);
            tick();
            want_psr = (i == 0) ? 3'b010 : 3'b001;
            checks++; if (wb1_if.psr !== want_psr) begin errors++;
                $display("FAIL t6_psr i=%0d: got %b want %b", i, wb1_if.psr, want_psr); end
        end
        wb1_if.enable_writeback = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wb1_if.sr1 = 3'(i);
            wb1_if.sr2 = 3'(i);
            #1;
            checks++; if (wb1_if.VSR1 !== 16'(16'h0010 * i)) begin errors++;
                $display("FAIL t6_vsr1 R%0d: got %h want %h", i, wb1_if.VSR1, 16'(16'h10 * i)); end
            checks++; if (wb0_if.VSR2 !== 16'(16'h0010 * i)) begin errors++;
                $display("FAIL t6_vsr2 R%0d: got %h want %h", i, wb0_if.VSR2, 16'(16'h10 * i)); end
        end
    endtask

    function automatic logic [15:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 16'd0;
            1:       return 16'h8000 | 16'($urandom);
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random();
        logic [15:0] e1, e2, e3, e4;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 31) != 0);
            set_in($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom), rand_val(),
                   1'($urandom), rand_val(), rand_val());
            wb1_if.sr1 = ($urandom_range(0, 2) == 0) ? wb1_if.dr : 3'($urandom);
            wb1_if.sr2 = ($urandom_range(0, 2) == 0) ? wb1_if.dr : 3'($urandom);
            #1;
            if (reset) begin
                e1 = exp_read(wb1_if.sr1, 1'b1);
                e2 = exp_read(wb1_if.sr2, 1'b1);
                e3 = exp_read(wb1_if.sr1, 1'b0);
                e4 = exp_read(wb1_if.sr2, 1'b0);
                checks++; if (wb1_if.VSR1 !== e1) begin errors++;
                    $display("FAIL rnd_byp_vsr1 n=%0d: got %h want %h", n, wb1_if.VSR1, e1); end
                checks++; if (wb1_if.VSR2 !== e2) begin errors++;
                    $display("FAIL rnd_byp_vsr2 n=%0d: got %h want %h", n, wb1_if.VSR2, e2); end
                checks++; if (wb0_if.VSR1 !== e3) begin errors++;
                    $display("FAIL rnd_nobyp_vsr1 n=%0d: got %h want %h", n, wb0_if.VSR1, e3); end
                checks++; if (wb0_if.VSR2 !== e4) begin errors++;
                    $display("FAIL rnd_nobyp_vsr2 n=%0d: got %h want %h", n, wb0_if.VSR2, e4); end
            end
            tick();
            checks++; if (wb1_if.psr !== m_psr) begin errors++;
                $display("FAIL rnd_psr n=%0d: got %b want %b", n, wb1_if.psr, m_psr); end
            checks++; if (wb1_if.carry_flag !== m_carry) begin errors++;
                $display("FAIL rnd_carry n=%0d: got %b want %b", n, wb1_if.carry_flag, m_carry); end
            checks++; if (wb1_if.wb_illegal !== m_ill) begin errors++;
                $display("FAIL rnd_illegal n=%0d: got %b want %b", n, wb1_if.wb_illegal, m_ill); end
            checks++; if (wb0_if.psr !== m_psr) begin errors++;
                $display("FAIL rnd_nobyp_psr n=%0d: got %b want %b", n, wb0_if.psr, m_psr); end
        end
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_nzp();
        test_bypass();
        test_illegal();
        test_reset_collision();
        test_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
